// File: rtl/vec_lsu_pkg.sv
// Shared definitions for the vector load/store unit: element-width
// encodings, FSM state type and the bytes-per-register derivation.
package vec_lsu_pkg;

    localparam logic [1:0] EEW_8    = 2'd0;
    localparam logic [1:0] EEW_16   = 2'd1;
    localparam logic [1:0] EEW_32   = 2'd2;
    localparam logic [1:0] EEW_RSVD = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    // Bytes held by one vector register of the given bit width.
    function automatic int vlenb_of(input int vlen);
        return vlen / 8;
    endfunction

    // The reserved width encoding behaves as 32-bit elements.
    function automatic logic [1:0] eew_norm(input logic [1:0] eew);
        return (eew == EEW_RSVD) ? EEW_32 : eew;
    endfunction

endpackage

// File: rtl/lsu_addr_gen.sv
// Address generator for vec_lsu: walks element/byte indices and the running
// element address, and presents the current transaction address/length.
module lsu_addr_gen
    import vec_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            advance,
    input  logic [XLEN-1:0] cfg_base,
    input  logic [XLEN-1:0] cfg_step,
    input  logic [1:0]      cfg_eew,
    input  logic [XLEN-1:0] cfg_vl,
    input  logic            cfg_unit_load,
    input  logic            cfg_store,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] len,
    output logic [XLEN-1:0] elem_idx,
    output logic [XLEN-1:0] byte_idx,
    output logic            last
);

    logic [XLEN-1:0] elem_addr_q;
    logic [XLEN-1:0] step_q;
    logic [XLEN-1:0] vl_q;
    logic [XLEN-1:0] e_q;
    logic [XLEN-1:0] b_q;
    logic [1:0]      eew_q;
    logic            unit_load_q;
    logic            store_q;
    logic [XLEN-1:0] eb;

    assign eb       = XLEN'(1) << eew_q;
    assign elem_idx = e_q;
    assign byte_idx = b_q;

    // Latch the access shape at accept; step the byte index before the element.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem_addr_q <= '0;
            step_q      <= '0;
            vl_q        <= '0;
            e_q         <= '0;
            b_q         <= '0;
            eew_q       <= EEW_8;
            unit_load_q <= 1'b0;
            store_q     <= 1'b0;
        end else if (start) begin
            elem_addr_q <= cfg_base;
            step_q      <= cfg_step;
            vl_q        <= cfg_vl;
            e_q         <= '0;
            b_q         <= '0;
            eew_q       <= cfg_eew;
            unit_load_q <= cfg_unit_load;
            store_q     <= cfg_store;
        end else if (advance) begin
            if (store_q) begin
                if (b_q == eb - XLEN'(1)) begin
                    b_q         <= '0;
                    e_q         <= e_q + XLEN'(1);
                    elem_addr_q <= elem_addr_q + step_q;
                end else begin
                    b_q <= b_q + XLEN'(1);
                end
            end else begin
                e_q         <= e_q + XLEN'(1);
                elem_addr_q <= elem_addr_q + step_q;
            end
        end
    end

    // Current transaction shape and whether it is the final one.
    always_comb begin
        addr = elem_addr_q;
        len  = eb;
        last = (e_q == vl_q - XLEN'(1));
        if (unit_load_q) begin
            len  = vl_q << eew_q;
            last = 1'b1;
        end else if (store_q) begin
            addr = elem_addr_q + b_q;
            len  = XLEN'(1);
            last = (e_q == vl_q - XLEN'(1)) && (b_q == eb - XLEN'(1));
        end
    end

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store unit: accepts one vector memory instruction, issues
// byte-addressed transactions to the memory controller one at a time,
// gathers load bytes and returns a single-cycle writeback response.
//
// Handshakes: a request is taken in the cycle req_valid && req_ready, and
// req_ready is high only in IDLE. ls_valid is a one-cycle strobe with no
// back-pressure; the unit then waits for the one-cycle ls_done pulse before
// issuing again. resp_valid is a one-cycle pulse with no back-pressure.
module vec_lsu
    import vec_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int VLEN  = 128,
    parameter int VLENB = vlenb_of(VLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [4:0]      req_vd,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_stride,
    input  logic            req_unit,
    input  logic [1:0]      req_eew,
    input  logic [XLEN-1:0] req_vl,
    input  logic [VLEN-1:0] req_src,
    output logic            ls_valid,
    output logic            ls_we,
    output logic [XLEN-1:0] ls_addr,
    output logic [XLEN-1:0] ls_len,
    output logic [VLEN-1:0] ls_src,
    input  logic            ls_done,
    input  logic [VLEN-1:0] ls_data,
    output logic            resp_valid,
    output logic            resp_load,
    output logic            resp_wen,
    output logic [4:0]      resp_vd,
    output logic [VLEN-1:0] resp_data,
    output logic [1:0]      dbg_state
);

    lsu_state_t      state_q;
    lsu_state_t      state_d;

    logic            we_q;
    logic            unit_q;
    logic [1:0]      eew_q;
    logic [4:0]      vd_q;
    logic [XLEN-1:0] vl_q;
    logic [VLEN-1:0] src_q;
    logic [VLEN-1:0] buf_q;

    logic            accept;
    logic            advance;
    logic [1:0]      eew_n;
    logic [XLEN-1:0] eb_req;
    logic [XLEN-1:0] vl_max;
    logic [XLEN-1:0] vl_eff;
    logic [XLEN-1:0] eb_q;

    logic [XLEN-1:0] ag_addr;
    logic [XLEN-1:0] ag_len;
    logic [XLEN-1:0] ag_e;
    logic [XLEN-1:0] ag_b;
    logic            ag_last;

    logic [XLEN-1:0] gather_off;
    logic [XLEN-1:0] src_idx;
    logic [7:0]      src_byte;

    assign accept     = (state_q == LSU_IDLE) && req_valid;
    assign advance    = (state_q == LSU_WAIT) && ls_done;
    assign eew_n      = eew_norm(req_eew);
    assign eb_req     = XLEN'(1) << eew_n;
    assign vl_max     = XLEN'(VLENB) >> eew_n;
    assign vl_eff     = (req_vl < vl_max) ? req_vl : vl_max;
    assign eb_q       = XLEN'(1) << eew_q;
    assign gather_off = ag_e << eew_q;
    assign src_idx    = gather_off + ag_b;
    assign dbg_state  = state_q;

    lsu_addr_gen #(
        .XLEN (XLEN)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (accept),
        .advance       (advance),
        .cfg_base      (req_addr),
        .cfg_step      (req_unit ? eb_req : req_stride),
        .cfg_eew       (eew_n),
        .cfg_vl        (vl_eff),
        .cfg_unit_load (req_unit && !req_we),
        .cfg_store     (req_we),
        .addr          (ag_addr),
        .len           (ag_len),
        .elem_idx      (ag_e),
        .byte_idx      (ag_b),
        .last          (ag_last)
    );

    // Pick the store byte e*eb+b out of the latched source register.
    always_comb begin
        src_byte = 8'h00;
        for (int k = 0; k < VLENB; k++) begin
            if (XLEN'(k) == src_idx) begin
                src_byte = src_q[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch request fields on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            unit_q <= 1'b0;
            eew_q  <= EEW_8;
            vd_q   <= '0;
            vl_q   <= '0;
            src_q  <= '0;
        end else if (accept) begin
            we_q   <= req_we;
            unit_q <= req_unit;
            eew_q  <= eew_n;
            vd_q   <= req_vd;
            vl_q   <= vl_eff;
            src_q  <= req_src;
        end
    end

    // Gather buffer: cleared on accept so tail bytes stay zero, filled on ls_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (accept) begin
            buf_q <= '0;
        end else if (advance && !we_q) begin
            for (int k = 0; k < VLENB; k++) begin
                if (unit_q) begin
                    if (XLEN'(k) < ag_len) begin
                        buf_q[8*k +: 8] <= ls_data[8*k +: 8];
                    end
                end else begin
                    for (int j = 0; j < 4; j++) begin
                        if ((XLEN'(j) < eb_q) && (XLEN'(k) == gather_off + XLEN'(j))) begin
                            buf_q[8*k +: 8] <= ls_data[8*j +: 8];
                        end
                    end
                end
            end
        end
    end

    // Next-state and all outputs; everything defaults to zero outside its state.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        ls_valid   = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = '0;
        ls_len     = '0;
        ls_src     = '0;
        resp_valid = 1'b0;
        resp_load  = 1'b0;
        resp_wen   = 1'b0;
        resp_vd    = '0;
        resp_data  = '0;
        case (state_q)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (vl_eff == '0) ? LSU_RESP : LSU_ISSUE;
                end
            end
            LSU_ISSUE: begin
                ls_valid = 1'b1;
                ls_we    = we_q;
                ls_addr  = ag_addr;
                ls_len   = ag_len;
                ls_src   = we_q ? VLEN'(src_byte) : '0;
                state_d  = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (ls_done) begin
                    state_d = ag_last ? LSU_RESP : LSU_ISSUE;
                end
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                resp_load  = !we_q;
                resp_wen   = !we_q && (vl_q != '0);
                resp_vd    = vd_q;
                resp_data  = we_q ? '0 : buf_q;
                state_d    = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_lsu.sv
// Directed bench for vec_lsu with a simple memory responder whose byte at
// address a is a[7:0].
module tb_vec_lsu;

    localparam int XLEN  = 32;
    localparam int VLEN  = 128;
    localparam int VLENB = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [4:0]      req_vd = '0;
    logic [XLEN-1:0] req_addr = '0;
    logic [XLEN-1:0] req_stride = '0;
    logic            req_unit = 1'b0;
    logic [1:0]      req_eew = '0;
    logic [XLEN-1:0] req_vl = '0;
    logic [VLEN-1:0] req_src = '0;
    logic            ls_valid;
    logic            ls_we;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_len;
    logic [VLEN-1:0] ls_src;
    logic            ls_done = 1'b0;
    logic [VLEN-1:0] ls_data = '0;
    logic            resp_valid;
    logic            resp_load;
    logic            resp_wen;
    logic [4:0]      resp_vd;
    logic [VLEN-1:0] resp_data;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    bit mem_en = 1'b1;
    int acc_cyc = -1;
    int done_cyc = -1;
    int r_cnt = 0;
    int r_cyc = -1;
    logic            r_load;
    logic            r_wen;
    logic [4:0]      r_vd;
    logic [VLEN-1:0] r_data;
    logic            prev_lsv = 1'b0;

    logic [XLEN-1:0] t_addr[$];
    logic [XLEN-1:0] t_len[$];
    logic            t_we[$];
    logic [VLEN-1:0] t_src[$];
    int              t_cyc[$];

    vec_lsu #(.XLEN(XLEN), .VLEN(VLEN), .VLENB(VLENB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_vd     (req_vd),
        .req_addr   (req_addr),
        .req_stride (req_stride),
        .req_unit   (req_unit),
        .req_eew    (req_eew),
        .req_vl     (req_vl),
        .req_src    (req_src),
        .ls_valid   (ls_valid),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_len     (ls_len),
        .ls_src     (ls_src),
        .ls_done    (ls_done),
        .ls_data    (ls_data),
        .resp_valid (resp_valid),
        .resp_load  (resp_load),
        .resp_wen   (resp_wen),
        .resp_vd    (resp_vd),
        .resp_data  (resp_data),
        .dbg_state  (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [VLEN-1:0] mem_read(input logic [XLEN-1:0] a);
        logic [VLEN-1:0]  d;
        logic [XLEN-1:0] ak;
        d = '0;
        for (int k = 0; k < VLENB; k++) begin
            ak = a + XLEN'(k);
            d[8*k +: 8] = ak[7:0];
        end
        return d;
    endfunction

    // Monitor and memory responder, sampling mid-cycle after the drivers.
    initial begin : monitor
        int pend;
        logic [VLEN-1:0] pend_data;
        pend = -1;
        pend_data = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            ls_done = 1'b0;
            ls_data = '0;
            if (pend == 0) begin
                ls_done  = 1'b1;
                ls_data  = pend_data;
                done_cyc = cyc;
                pend     = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) acc_cyc = cyc;
            if (ls_valid === 1'b1) begin
                checks++;
                if (prev_lsv) begin
                    errors++;
                    $display("FAIL strobe_adjacent: ls_valid high in cycle %0d and %0d, required never adjacent", cyc - 1, cyc);
                end
                t_addr.push_back(ls_addr);
                t_len.push_back(ls_len);
                t_we.push_back(ls_we);
                t_src.push_back(ls_src);
                t_cyc.push_back(cyc);
                if (mem_en) begin
                    pend      = 0;
                    pend_data = mem_read(ls_addr);
                end
            end
            prev_lsv = (ls_valid === 1'b1);
            if (resp_valid === 1'b1) begin
                r_cnt++;
                r_cyc  = cyc;
                r_load = resp_load;
                r_wen  = resp_wen;
                r_vd   = resp_vd;
                r_data = resp_data;
            end
        end
    end

    task automatic clear_log();
        t_addr.delete();
        t_len.delete();
        t_we.delete();
        t_src.delete();
        t_cyc.delete();
    endtask

    task automatic drive_req(input logic we, input logic [4:0] vd, input logic [XLEN-1:0] addr,
                             input logic [XLEN-1:0] stride, input logic unit, input logic [1:0] eew,
                             input logic [XLEN-1:0] vl, input logic [VLEN-1:0] src);
        req_we     = we;
        req_vd     = vd;
        req_addr   = addr;
        req_stride = stride;
        req_unit   = unit;
        req_eew    = eew;
        req_vl     = vl;
        req_src    = src;
        req_valid  = 1'b1;
    endtask

    // Returns just after the accepting edge.
    task automatic wait_accept(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (req_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_accept: request not accepted within 300 cycles", name);
        end
    endtask

    task automatic wait_resp(input string name, input int target);
        for (int i = 0; i < 300; i++) begin
            if (r_cnt >= target) break;
            @(negedge clk);
        end
        checks++;
        if (r_cnt < target) begin
            errors++;
            $display("FAIL %s_resp: response count %0d, required %0d", name, r_cnt, target);
        end
    endtask

    task automatic run_req(input string name, input logic we, input logic [4:0] vd,
                           input logic [XLEN-1:0] addr, input logic [XLEN-1:0] stride,
                           input logic unit, input logic [1:0] eew, input logic [XLEN-1:0] vl,
                           input logic [VLEN-1:0] src);
        int target;
        target = r_cnt + 1;
        clear_log();
        @(negedge clk);
        drive_req(we, vd, addr, stride, unit, eew, vl, src);
        wait_accept(name);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(name, target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
        checks++;
        if (ls_valid !== 1'b0 || ls_addr !== '0 || ls_len !== '0 || ls_src !== '0 || ls_we !== 1'b0) begin
            errors++; $display("FAIL reset_ls: valid=%b addr=%h len=%h, required all 0", ls_valid, ls_addr, ls_len);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== '0 || resp_wen !== 1'b0 || resp_vd !== '0 || resp_load !== 1'b0) begin
            errors++; $display("FAIL reset_resp: valid=%b data=%h, required all 0", resp_valid, resp_data);
        end
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unit_load();
        run_req("unit_load", 1'b0, 5'd3, 32'h100, 32'h0, 1'b1, 2'd2, 32'd4, '0);
        checks++;
        if (t_addr.size() != 1) begin
            errors++; $display("FAIL unit_load_count: got %0d transactions, required 1", t_addr.size());
        end else begin
            checks++;
            if (t_addr[0] !== 32'h100 || t_len[0] !== 32'd16 || t_we[0] !== 1'b0) begin
                errors++; $display("FAIL unit_load_txn: addr=%h len=%0d we=%b, required 100/16/0", t_addr[0], t_len[0], t_we[0]);
            end
            checks++;
            if (t_cyc[0] != acc_cyc + 1) begin
                errors++; $display("FAIL unit_load_issue_lat: strobe cycle %0d, required %0d", t_cyc[0], acc_cyc + 1);
            end
        end
        checks++;
        if (r_data !== 128'h0f0e0d0c_0b0a0908_07060504_03020100) begin
            errors++; $display("FAIL unit_load_data: got %h, required 0f0e..0100", r_data);
        end
        checks++;
        if (r_wen !== 1'b1 || r_load !== 1'b1 || r_vd !== 5'd3) begin
            errors++; $display("FAIL unit_load_resp: wen=%b load=%b vd=%0d, required 1/1/3", r_wen, r_load, r_vd);
        end
        checks++;
        if (r_cyc != done_cyc + 1) begin
            errors++; $display("FAIL unit_load_resp_lat: resp cycle %0d, required %0d", r_cyc, done_cyc + 1);
        end
    endtask

    task automatic test_strided_load();
        logic [XLEN-1:0] exp_a[3];
        exp_a[0] = 32'h40; exp_a[1] = 32'h38; exp_a[2] = 32'h30;
        run_req("strided_load", 1'b0, 5'd7, 32'h40, 32'hffff_fff8, 1'b0, 2'd1, 32'd3, '0);
        checks++;
        if (t_addr.size() != 3) begin
            errors++; $display("FAIL strided_load_count: got %0d transactions, required 3", t_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (t_addr[i] !== exp_a[i] || t_len[i] !== 32'd2) begin
                    errors++; $display("FAIL strided_load_txn%0d: addr=%h len=%0d, required %h/2", i, t_addr[i], t_len[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (r_data !== 128'h00000000_00000000_00003130_39384140) begin
            errors++; $display("FAIL strided_load_data: got %h, required ..3130_39384140", r_data);
        end
        checks++;
        if (r_vd !== 5'd7 || r_wen !== 1'b1) begin
            errors++; $display("FAIL strided_load_resp: vd=%0d wen=%b, required 7/1", r_vd, r_wen);
        end
    endtask

    task automatic test_unit_store();
        logic [7:0] exp_b[3];
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC;
        run_req("unit_store", 1'b1, 5'd9, 32'h200, 32'h0, 1'b1, 2'd0, 32'd3, 128'hCCBBAA);
        checks++;
        if (t_addr.size() != 3) begin
            errors++; $display("FAIL unit_store_count: got %0d transactions, required 3", t_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (t_addr[i] !== 32'h200 + 32'(i) || t_len[i] !== 32'd1 || t_we[i] !== 1'b1 || t_src[i] !== VLEN'(exp_b[i])) begin
                    errors++; $display("FAIL unit_store_txn%0d: addr=%h len=%0d we=%b src=%h, required %h/1/1/%h",
                                       i, t_addr[i], t_len[i], t_we[i], t_src[i], 32'h200 + 32'(i), exp_b[i]);
                end
            end
        end
        checks++;
        if (r_load !== 1'b0 || r_wen !== 1'b0 || r_data !== '0) begin
            errors++; $display("FAIL unit_store_resp: load=%b wen=%b data=%h, required 0/0/0", r_load, r_wen, r_data);
        end
    endtask

    task automatic test_strided_store();
        logic [XLEN-1:0] exp_a[4];
        logic [7:0]      exp_b[4];
        exp_a[0] = 32'h300; exp_a[1] = 32'h301; exp_a[2] = 32'h310; exp_a[3] = 32'h311;
        exp_b[0] = 8'h11;   exp_b[1] = 8'h22;   exp_b[2] = 8'h33;   exp_b[3] = 8'h44;
        run_req("strided_store", 1'b1, 5'd1, 32'h300, 32'h10, 1'b0, 2'd1, 32'd2, 128'h44332211);
        checks++;
        if (t_addr.size() != 4) begin
            errors++; $display("FAIL strided_store_count: got %0d transactions, required 4", t_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (t_addr[i] !== exp_a[i] || t_src[i] !== VLEN'(exp_b[i]) || t_len[i] !== 32'd1) begin
                    errors++; $display("FAIL strided_store_txn%0d: addr=%h src=%h len=%0d, required %h/%h/1",
                                       i, t_addr[i], t_src[i], t_len[i], exp_a[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_vl_zero_and_clamp();
        run_req("vl_zero", 1'b0, 5'd4, 32'h100, 32'h0, 1'b1, 2'd2, 32'd0, '0);
        checks++;
        if (t_addr.size() != 0) begin
            errors++; $display("FAIL vl_zero_count: got %0d transactions, required 0", t_addr.size());
        end
        checks++;
        if (r_cyc != acc_cyc + 1 || r_wen !== 1'b0 || r_load !== 1'b1 || r_data !== '0) begin
            errors++; $display("FAIL vl_zero_resp: cycle %0d wen=%b data=%h, required %0d/0/0", r_cyc, r_wen, r_data, acc_cyc + 1);
        end
        run_req("clamp", 1'b0, 5'd5, 32'h100, 32'h0, 1'b1, 2'd2, 32'd100, '0);
        checks++;
        if (t_len.size() != 1 || t_len[0] !== 32'd16) begin
            errors++; $display("FAIL clamp_len: got %0d transactions, required one of len 16", t_len.size());
        end
        checks++;
        if (r_data !== 128'h0f0e0d0c_0b0a0908_07060504_03020100) begin
            errors++; $display("FAIL clamp_data: got %h, required 0f0e..0100", r_data);
        end
        run_req("short_unit", 1'b0, 5'd6, 32'h100, 32'h0, 1'b1, 2'd0, 32'd2, '0);
        checks++;
        if (t_len.size() != 1 || t_len[0] !== 32'd2 || r_data !== 128'h0100) begin
            errors++; $display("FAIL short_unit: data=%h, required 0100 with one len-2 transaction", r_data);
        end
    endtask

    task automatic test_reset_mid();
        int cnt0;
        bit seen;
        clear_log();
        mem_en = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 5'd2, 32'h80, 32'h4, 1'b0, 2'd0, 32'd4, '0);
        wait_accept("reset_mid");
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state === 2'd2) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_mid_wait: state %0d, required 2", dbg_state); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ls_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs: ls_valid=%b req_ready=%b resp_valid=%b, required 0/1/0", ls_valid, req_ready, resp_valid);
        end
        rst_n = 1'b1;
        mem_en = 1'b1;
        cnt0 = r_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (r_cnt != cnt0) begin errors++; $display("FAIL reset_mid_noresp: got %0d responses, required %0d", r_cnt, cnt0); end
        run_req("after_reset", 1'b0, 5'd8, 32'h100, 32'h0, 1'b1, 2'd2, 32'd4, '0);
        checks++;
        if (r_data !== 128'h0f0e0d0c_0b0a0908_07060504_03020100 || r_vd !== 5'd8) begin
            errors++; $display("FAIL after_reset_data: got %h vd=%0d, required 0f0e..0100 vd=8", r_data, r_vd);
        end
    endtask

    task automatic test_back_to_back();
        int base_cnt;
        int first_r;
        clear_log();
        base_cnt = r_cnt;
        @(negedge clk);
        drive_req(1'b1, 5'd10, 32'h500, 32'h4, 1'b0, 2'd0, 32'd2, 128'hBEEF);
        wait_accept("b2b_first");
        @(negedge clk);
        drive_req(1'b0, 5'd11, 32'h100, 32'h0, 1'b1, 2'd0, 32'd2, '0);
        wait_accept("b2b_second");
        first_r = r_cyc;
        checks++;
        if (r_cnt != base_cnt + 1 || acc_cyc != first_r + 1) begin
            errors++; $display("FAIL b2b_accept: second accept cycle %0d with %0d responses, required %0d with %0d",
                               acc_cyc, r_cnt - base_cnt, first_r + 1, 1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp("b2b", base_cnt + 2);
        checks++;
        if (t_addr.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d transactions, required 3", t_addr.size());
        end else begin
            checks++;
            if (t_addr[0] !== 32'h500 || t_src[0] !== 128'hEF || t_addr[1] !== 32'h504 || t_src[1] !== 128'hBE) begin
                errors++; $display("FAIL b2b_store: %h/%h %h/%h, required 500/ef 504/be", t_addr[0], t_src[0], t_addr[1], t_src[1]);
            end
        end
        checks++;
        if (r_data !== 128'h0100 || r_vd !== 5'd11) begin
            errors++; $display("FAIL b2b_load: data=%h vd=%0d, required 0100/11", r_data, r_vd);
        end
    endtask

    initial begin
        test_reset();
        test_unit_load();
        test_strided_load();
        test_unit_store();
        test_strided_store();
        test_vl_zero_and_clamp();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_lsu.md
# vec_lsu

Vector load/store unit between the issue stage and the memory controller's B port (`ls_*` handshake). Takes one vector memory instruction at a time (unit-stride or strided, element width 8/16/32), breaks it into byte-addressed memory-controller transactions, and gathers load bytes into a VLEN-wide result. Returns a single-cycle response carrying the destination register and load data for register-file writeback.

## Interface

Parameters:

- `XLEN`, default 32, scalar/address width.
- `VLEN`, default 128, vector register width in bits.
- `VLENB`, default `VLEN/8`, bytes per vector register.

Ports:

- `clk`, in, 1, clock; all logic on the rising edge.
- `rst_n`, in, 1, synchronous, active-low reset.
- `req_valid`, in, 1, issue request present.
- `req_ready`, out, 1, high only in IDLE.
- `req_we`, in, 1, 1 = store, 0 = load.
- `req_vd`, in, 5, destination register (load) or source register tag (store).
- `req_addr`, in, XLEN, base byte address.
- `req_stride`, in, XLEN, signed byte stride; ignored when `req_unit` = 1.
- `req_unit`, in, 1, unit-stride access.
- `req_eew`, in, 2, element width: 0 = 1 B, 1 = 2 B, 2 = 4 B; 3 is treated as 2.
- `req_vl`, in, XLEN, element count.
- `req_src`, in, VLEN, store data; element i occupies bytes `[i*eb, i*eb+eb)`.
- `ls_valid`, out, 1, one-cycle transaction strobe to the memory controller.
- `ls_we`, out, 1, write enable for the transaction.
- `ls_addr`, out, XLEN, transaction start address.
- `ls_len`, out, XLEN, transaction byte count.
- `ls_src`, out, VLEN, store byte in bits [7:0]; upper bits are zero.
- `ls_done`, in, 1, one-cycle completion pulse.
- `ls_data`, in, VLEN, load bytes; byte k in bits [8k+7:8k].
- `resp_valid`, out, 1, one-cycle completion pulse.
- `resp_load`, out, 1, response belongs to a load.
- `resp_wen`, out, 1, register-file write enable; 1 only for a load with vl > 0.
- `resp_vd`, out, 5, latched `req_vd`.
- `resp_data`, out, VLEN, gathered load data; zero for stores.

## Operation

- **Definitions.**
  - eb = 1 << eew.
  - Effective vl = min(`req_vl`, VLENB/eb); the unit clamps silently.
  - Addresses are computed modulo 2^XLEN. The stride is two's complement.
- **State machine.** States are IDLE, ISSUE, WAIT, RESP.
- **IDLE.**
  - `req_ready` = 1.
  - On `req_valid`, latch all `req_*` fields and clear the element index e, the byte index b, and the gather buffer (all zeros).
  - If effective vl = 0, go to RESP; otherwise go to ISSUE.
- **ISSUE.** Drive `ls_valid` = 1 for exactly one cycle with the current transaction, then go to WAIT.
- **Load, unit-stride.** One transaction: addr = base, len = vl*eb. On `ls_done`, copy bytes [0, vl*eb) of `ls_data` into the buffer.
- **Load, strided.** One transaction per element: addr = base + e*stride, len = eb. On `ls_done`, place bytes [0, eb) at buffer bytes [e*eb, e*eb+eb).
- **Store (unit-stride or strided).** One transaction per byte: addr = element address + b, len = 1, `ls_src`[7:0] = source byte e*eb+b. The byte index b advances before e.
- **WAIT.**
  - Ignore all inputs except `ls_done`.
  - On `ls_done`, perform the capture/advance above.
  - If work remains, go to ISSUE; otherwise go to RESP.
- **RESP.**
  - `resp_valid` = 1 for one cycle.
  - `resp_data` = buffer; tail bytes ≥ vl*eb are zero (tail-zero policy).
  - Then go to IDLE.
- **Request acceptance.** At most one request is in flight. No new request is accepted until the cycle after RESP.

## Timing

- **Reset values.** With `rst_n` = 0 at a clock edge, the block enters IDLE and every output is 0 except `req_ready` = 1 in the following cycle.
  - This applies mid-transaction too: `ls_valid` drops and no response is produced.
  - The top level resets the memory controller in the same cycle (`rst` = ~`rst_n`).
- **Memory strobe rule.** `ls_valid` is never high in two consecutive cycles. It is never re-asserted before the cycle after `ls_done`. The memory controller re-arms only in its idle state.
- **Transaction fields.** `ls_we`, `ls_addr`, `ls_len`, `ls_src` are valid only while `ls_valid` = 1 and are otherwise 0.
- **Latency.** Accept → first `ls_valid`: 1 cycle. Final `ls_done` → `resp_valid`: 1 cycle. vl = 0: accept → `resp_valid` in 1 cycle.
- **Stray `ls_done`.** `ls_done` arriving outside WAIT is ignored.

## Structure

- Shared package:
  - `EEW_*` encodings.
  - State enum `LSU_IDLE/ISSUE/WAIT/RESP`.
  - `VLENB` derivation.
- Sub-module `lsu_addr_gen`:
  - Holds e/b counters and the running element address (base, then += stride per element).
  - Produces the `ls_addr`, `ls_len`, and `last` flags.
- The top of `vec_lsu` holds the FSM, the gather buffer, and the response registers.

## Test plan

- Unit-stride load: eew=2, vl=4, addr=0x100, mem = 0x00..0x0F → one transaction (addr 0x100, len 16); `resp_data` = bytes 0x00..0x0F, `resp_wen` = 1.
- Strided load: eew=1, vl=3, stride=−8, base=0x40 → transactions at 0x40/0x38/0x30, each len 2; elements packed into bytes 0–5; bytes 6–15 = 0.
- Unit-stride store: eew=0, vl=3, `req_src` bytes AA,BB,CC → three len-1 writes to base, base+1, base+2 with `ls_src` = 0xAA/0xBB/0xCC; `resp_load` = 0, `resp_wen` = 0.
- vl=0 load → no `ls_valid`; `resp_valid` one cycle after accept with `resp_wen` = 0. vl=100, eew=2 → clamped to 4 elements, len 16.
- `rst_n` low while in WAIT → `ls_valid` = 0 and `req_ready` = 1 next cycle, no `resp_valid`. A following request completes normally.
- Back-to-back requests with `req_valid` held high → the second is accepted only after `resp_valid`; `ls_valid` never high in adjacent cycles.
